// File: rtl/lc3_mem_responder.sv
// LC3 instruction/data memory responder: two independent IDLE/WAIT/RESP ports over one word array, plus a preload port.
// Latency 1+W cycles from accept to complete_*; W is T_*_MAX, or LFSR-drawn when LC3_MEM_RAND_WAIT_EN is defined.
// No backpressure: a request arriving while its port is busy is ignored; completion is a one-cycle pulse.
module lc3_mem_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h3000,
  parameter int          MEM_AW      = 12,
  parameter int          T_FETCH_MAX = 0,
  parameter int          T_DATA_MAX  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        data_req,
  input  logic [15:0] Data_addr,
  input  logic        Data_rd,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        oob_err
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} st_t;

  st_t         i_st, i_nxt, d_st, d_nxt;
  logic [3:0]  i_cnt, i_cnt_nxt, d_cnt, d_cnt_nxt;
  logic [3:0]  i_w, d_w;
  logic [15:0] i_addr_q, d_addr_q, d_din_q;
  logic        d_rd_q;

  logic [15:0] i_addr_eff, d_addr_eff, d_din_eff;
  logic        d_rd_eff;
  logic [15:0] i_off, d_off, ld_off;
  logic        i_win, d_win, ld_win;
  logic        i_fire, d_fire, d_commit;

  logic [15:0] mem [DEPTH];

`ifdef LC3_MEM_RAND_WAIT_EN
  localparam logic [4:0] I_MOD = 5'(T_FETCH_MAX + 1);
  localparam logic [4:0] D_MOD = 5'(T_DATA_MAX + 1);
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; free-running so each accept draws a fresh W.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign i_w = 4'({1'b0, lfsr[3:0]} % I_MOD);
  assign d_w = 4'({1'b0, lfsr[3:0]} % D_MOD);
`else
  assign i_w = 4'(T_FETCH_MAX);
  assign d_w = 4'(T_DATA_MAX);
`endif

  // State registers; request fields are captured every idle cycle so the accepted one is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      i_st  <= IDLE;
      d_st  <= IDLE;
      i_cnt <= '0;
      d_cnt <= '0;
    end else begin
      i_st  <= i_nxt;
      d_st  <= d_nxt;
      i_cnt <= i_cnt_nxt;
      d_cnt <= d_cnt_nxt;
    end
    if (i_st == IDLE) i_addr_q <= pc;
    if (d_st == IDLE) begin
      d_addr_q <= Data_addr;
      d_rd_q   <= Data_rd;
      d_din_q  <= Data_din;
    end
  end

  always_comb begin
    i_nxt     = i_st;
    i_cnt_nxt = i_cnt;
    if (reset) begin
      i_nxt     = IDLE;
      i_cnt_nxt = '0;
    end else begin
      case (i_st)
        IDLE: if (instrmem_rd) begin
          i_cnt_nxt = i_w;
          i_nxt     = (i_w != 4'd0) ? WAIT : RESP;
        end
        WAIT: begin
          i_cnt_nxt = i_cnt - 4'd1;
          if (i_cnt == 4'd1) i_nxt = RESP;
        end
        default: i_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    d_nxt     = d_st;
    d_cnt_nxt = d_cnt;
    if (reset) begin
      d_nxt     = IDLE;
      d_cnt_nxt = '0;
    end else begin
      case (d_st)
        IDLE: if (data_req) begin
          d_cnt_nxt = d_w;
          d_nxt     = (d_w != 4'd0) ? WAIT : RESP;
        end
        WAIT: begin
          d_cnt_nxt = d_cnt - 4'd1;
          if (d_cnt == 4'd1) d_nxt = RESP;
        end
        default: d_nxt = IDLE;
      endcase
    end
  end

  // A zero-wait accept enters RESP on the accept edge itself, so use the live inputs then.
  always_comb begin
    complete_instr = (i_st == RESP);
    complete_data  = (d_st == RESP);
    i_addr_eff     = (i_st == IDLE) ? pc        : i_addr_q;
    d_addr_eff     = (d_st == IDLE) ? Data_addr : d_addr_q;
    d_rd_eff       = (d_st == IDLE) ? Data_rd   : d_rd_q;
    d_din_eff      = (d_st == IDLE) ? Data_din  : d_din_q;
    i_off          = i_addr_eff - BASE_ADDR;
    d_off          = d_addr_eff - BASE_ADDR;
    ld_off         = ld_addr - BASE_ADDR;
    i_win          = ({1'b0, i_off}  < (17'd1 << MEM_AW));
    d_win          = ({1'b0, d_off}  < (17'd1 << MEM_AW));
    ld_win         = ({1'b0, ld_off} < (17'd1 << MEM_AW));
    i_fire         = (i_nxt == RESP) && (i_st != RESP);
    d_fire         = (d_nxt == RESP) && (d_st != RESP);
    d_commit       = d_fire && !d_rd_eff && d_win;
  end

  // Preload is listed last so it overrides a data write to the same word on the same edge.
  always_ff @(posedge clock) begin
    if (d_commit) mem[d_off[MEM_AW-1:0]] <= d_din_eff;
    if (ld_we && ld_win) mem[ld_off[MEM_AW-1:0]] <= ld_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Instr_dout <= '0;
      Data_dout  <= '0;
      oob_err    <= 1'b0;
    end else begin
      if (i_fire) Instr_dout <= i_win ? mem[i_off[MEM_AW-1:0]] : 16'h0000;
      if (d_fire && d_rd_eff) Data_dout <= d_win ? mem[d_off[MEM_AW-1:0]] : 16'h0000;
      if ((i_fire && !i_win) || (d_fire && !d_win)) oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench: instance a (fetch W=0, data W=3) and instance b (fetch W=5, data max 7).
module tb_lc3_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, ird_a, ci_a, dreq_a, drd_a, cd_a, ldwe_a, oob_a;
  logic [15:0] pc_a, idout_a, daddr_a, ddin_a, ddout_a, ldaddr_a, lddata_a;
  logic        rst_b, ird_b, ci_b, dreq_b, drd_b, cd_b, ldwe_b, oob_b;
  logic [15:0] pc_b, idout_b, daddr_b, ddin_b, ddout_b, ldaddr_b, lddata_b;

  lc3_mem_responder #(.BASE_ADDR(16'h3000), .MEM_AW(12), .T_FETCH_MAX(0), .T_DATA_MAX(3)) dut_a (
    .clock(clk), .reset(rst_a), .pc(pc_a), .instrmem_rd(ird_a), .Instr_dout(idout_a),
    .complete_instr(ci_a), .data_req(dreq_a), .Data_addr(daddr_a), .Data_rd(drd_a),
    .Data_din(ddin_a), .Data_dout(ddout_a), .complete_data(cd_a), .ld_we(ldwe_a),
    .ld_addr(ldaddr_a), .ld_data(lddata_a), .oob_err(oob_a));

  lc3_mem_responder #(.BASE_ADDR(16'h3000), .MEM_AW(12), .T_FETCH_MAX(5), .T_DATA_MAX(7)) dut_b (
    .clock(clk), .reset(rst_b), .pc(pc_b), .instrmem_rd(ird_b), .Instr_dout(idout_b),
    .complete_instr(ci_b), .data_req(dreq_b), .Data_addr(daddr_b), .Data_rd(drd_b),
    .Data_din(ddin_b), .Data_dout(ddout_b), .complete_data(cd_b), .ld_we(ldwe_b),
    .ld_addr(ldaddr_b), .ld_data(lddata_b), .oob_err(oob_b));

  int n_checks = 0;
  int n_errors = 0;
  int lat1 [1000];
  int lat2 [1000];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_a(input logic [15:0] a, output int lat);
    pc_a = a; ird_a = 1'b1;
    tick(); ird_a = 1'b0; lat = 1;
    while (ci_a !== 1'b1 && lat < 40) begin tick(); lat++; end
    tick();
  endtask

  task automatic data_a(input logic [15:0] a, input logic rd, input logic [15:0] din, output int lat);
    daddr_a = a; drd_a = rd; ddin_a = din; dreq_a = 1'b1;
    tick(); dreq_a = 1'b0; lat = 1;
    while (cd_a !== 1'b1 && lat < 40) begin tick(); lat++; end
    tick();
  endtask

  task automatic fetch_b(input logic [15:0] a, output int lat);
    pc_b = a; ird_b = 1'b1;
    tick(); ird_b = 1'b0; lat = 1;
    while (ci_b !== 1'b1 && lat < 40) begin tick(); lat++; end
    tick();
  endtask

  task automatic data_b(input logic [15:0] a, input logic rd, input logic [15:0] din, output int lat);
    daddr_b = a; drd_b = rd; ddin_b = din; dreq_b = 1'b1;
    tick(); dreq_b = 1'b0; lat = 1;
    while (cd_b !== 1'b1 && lat < 40) begin tick(); lat++; end
    tick();
  endtask

  initial begin
    int lat;
    int seen;
    int bad_range;
    int bad_seq;
    int bad_fixed;
    rst_a = 1'b1; ird_a = 1'b0; pc_a = '0; dreq_a = 1'b0; daddr_a = '0; drd_a = 1'b0; ddin_a = '0;
    ldwe_a = 1'b0; ldaddr_a = '0; lddata_a = '0;
    rst_b = 1'b1; ird_b = 1'b0; pc_b = '0; dreq_b = 1'b0; daddr_b = '0; drd_b = 1'b0; ddin_b = '0;
    ldwe_b = 1'b0; ldaddr_b = '0; lddata_b = '0;
    tick();

    // Preload during reset while a fetch request is held (must be ignored).
    ird_a = 1'b1; pc_a = 16'h3000;
    ldwe_a = 1'b1; ldaddr_a = 16'h3000; lddata_a = 16'h1021;
    tick();
    ldaddr_a = 16'h3020; lddata_a = 16'h5555;
    tick();
    ldwe_a = 1'b0;
    check("rst_req_ignored", ci_a, 1'b0);
    ird_a = 1'b0; rst_a = 1'b0;
    tick();
    check("rst_instr_dout", idout_a, 16'h0000);
    check("rst_data_dout", ddout_a, 16'h0000);
    check("rst_complete_instr", ci_a, 1'b0);
    check("rst_complete_data", cd_a, 1'b0);
    check("rst_oob_err", oob_a, 1'b0);

    fetch_a(16'h3000, lat);
    check("fetch0_latency", lat, 1);
    check("fetch0_data", idout_a, 16'h1021);
    check("fetch0_pulse_width", ci_a, 1'b0);

    data_a(16'h3010, 1'b0, 16'hBEEF, lat);
    check("write3_latency", lat, 4);
    check("write_keeps_dout", ddout_a, 16'h0000);
    check("write3_pulse_width", cd_a, 1'b0);
    data_a(16'h3010, 1'b1, 16'h0000, lat);
    check("read3_latency", lat, 4);
    check("read3_data", ddout_a, 16'hBEEF);

    data_a(16'h2FFF, 1'b1, 16'h0000, lat);
    check("oob_read_latency", lat, 4);
    check("oob_read_data", ddout_a, 16'h0000);
    check("oob_flag_set", oob_a, 1'b1);
    data_a(16'h3000, 1'b1, 16'h0000, lat);
    check("oob_flag_sticky", oob_a, 1'b1);
    check("read_after_oob", ddout_a, 16'h1021);

    // Data write to 3020 commits on the same edge a zero-wait fetch of 3020 samples memory.
    daddr_a = 16'h3020; drd_a = 1'b0; ddin_a = 16'h0001; dreq_a = 1'b1;
    tick(); dreq_a = 1'b0;
    tick();
    tick();
    pc_a = 16'h3020; ird_a = 1'b1;
    tick(); ird_a = 1'b0;
    check("collide_complete_data", cd_a, 1'b1);
    check("collide_complete_instr", ci_a, 1'b1);
    check("collide_old_data", idout_a, 16'h5555);
    tick();
    fetch_a(16'h3020, lat);
    check("collide_new_data", idout_a, 16'h0001);

    // Preload and data write to the same word on one edge: preload wins.
    daddr_a = 16'h3030; drd_a = 1'b0; ddin_a = 16'hBBBB; dreq_a = 1'b1;
    tick(); dreq_a = 1'b0;
    tick();
    tick();
    ldwe_a = 1'b1; ldaddr_a = 16'h3030; lddata_a = 16'hAAAA;
    tick(); ldwe_a = 1'b0;
    check("ld_vs_write_complete", cd_a, 1'b1);
    tick();
    fetch_a(16'h3030, lat);
    check("ld_wins", idout_a, 16'hAAAA);

    // Out-of-window write at index 0x1000 must not alias onto word 0.
    data_a(16'h4000, 1'b0, 16'hDEAD, lat);
    check("oob_write_latency", lat, 4);
    fetch_a(16'h3000, lat);
    check("oob_write_dropped", idout_a, 16'h1021);

    rst_a = 1'b1;
    tick();
    tick();
    check("rst2_oob_clear", oob_a, 1'b0);
    check("rst2_instr_dout", idout_a, 16'h0000);
    check("rst2_data_dout", ddout_a, 16'h0000);
    rst_a = 1'b0;
    ldwe_a = 1'b1; ldaddr_a = 16'h2000; lddata_a = 16'h1234;
    tick(); ldwe_a = 1'b0;
    check("oob_preload_no_flag", oob_a, 1'b0);
    fetch_a(16'h3010, lat);
    check("mem_survives_reset", idout_a, 16'hBEEF);

    // Instance b: reset in the middle of a 5-wait fetch and a 7-wait write.
    ldwe_b = 1'b1; ldaddr_b = 16'h3005; lddata_b = 16'h7777;
    tick(); ldwe_b = 1'b0; rst_b = 1'b0;
    tick();
    pc_b = 16'h3005; ird_b = 1'b1;
    daddr_b = 16'h3005; drd_b = 1'b0; ddin_b = 16'h1111; dreq_b = 1'b1;
    tick(); ird_b = 1'b0; dreq_b = 1'b0;
    tick();
    rst_b = 1'b1;
    tick(); rst_b = 1'b0;
    check("abort_no_ci", ci_b, 1'b0);
    check("abort_no_cd", cd_b, 1'b0);
    check("abort_instr_dout", idout_b, 16'h0000);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ci_b === 1'b1 || cd_b === 1'b1) seen++;
    end
    check("abort_no_late_pulse", seen, 0);
    fetch_b(16'h3005, lat);
    check("abort_fsm_idle_latency", lat, 6);
    check("abort_write_dropped", idout_b, 16'h7777);

    // Latency sequence over 1000 reads, repeated after an identical reset.
    bad_range = 0; bad_seq = 0; bad_fixed = 0;
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      data_b(16'h3000 + 16'(i % 64), 1'b1, 16'h0000, lat);
      lat1[i] = lat;
    end
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      data_b(16'h3000 + 16'(i % 64), 1'b1, 16'h0000, lat);
      lat2[i] = lat;
    end
    for (int i = 0; i < 1000; i++) begin
      if (lat1[i] < 1 || lat1[i] > 8) bad_range++;
      if (lat1[i] != lat2[i]) bad_seq++;
      if (lat1[i] != 8) bad_fixed++;
    end
    check("lat_in_1_to_8", bad_range, 0);
    check("lat_repeatable", bad_seq, 0);
`ifndef LC3_MEM_RAND_WAIT_EN
    check("lat_fixed_8", bad_fixed, 0);
`endif
    check("lat_run_oob_clear", oob_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lc3_mem_responder.md
LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 The block SHALL have the parameter BASE_ADDR, default 16'h3000, meaning the first LC3 address mapped to memory word 0.
REQ-002 The block SHALL have the parameter MEM_AW, default 12, meaning log2 of the memory depth in 16-bit words.
REQ-003 The block SHALL have the parameter T_FETCH_MAX, default 0, meaning the instruction-port wait states (range 0..15).
REQ-004 The block SHALL have the parameter T_DATA_MAX, default 0, meaning the data-port wait states (range 0..15).
REQ-005 The block SHALL have the port clock  input  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have the port reset  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have the port pc  input  16  instruction fetch address.
REQ-008 The block SHALL have the port instrmem_rd  input  1  instruction fetch request.
REQ-009 The block SHALL have the port Instr_dout  output  16  fetched instruction.
REQ-010 The block SHALL have the port complete_instr  output  1  one-cycle fetch-done pulse.
REQ-011 The block SHALL have the port data_req  input  1  data access request.
REQ-012 The block SHALL have the port Data_addr  input  16  data address.
REQ-013 The block SHALL have the port Data_rd  input  1  access type: 1 = read, 0 = write.
REQ-014 The block SHALL have the port Data_din  input  16  write data from the LC3.
REQ-015 The block SHALL have the port Data_dout  output  16  read data to the LC3.
REQ-016 The block SHALL have the port complete_data  output  1  one-cycle data-done pulse.
REQ-017 The block SHALL have the port ld_we  input  1  preload write strobe.
REQ-018 The block SHALL have the port ld_addr  input  16  preload address.
REQ-019 The block SHALL have the port ld_data  input  16  preload data.
REQ-020 The block SHALL have the port oob_err  output  1  sticky out-of-window access flag.

Function
REQ-021 The instruction port and the data port SHALL each run an independent FSM with states IDLE, WAIT and RESP.
REQ-022 In IDLE, a sampled request SHALL latch the address (and, for data, Data_rd and Data_din), load the wait count W, and go to WAIT if W>0, else to RESP.
REQ-023 In WAIT, the count SHALL decrement each cycle and the FSM SHALL go to RESP on the edge where the count reaches 0.
REQ-024 In RESP, the port's complete_* SHALL be high for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-025 Latency SHALL be 1+W cycles from the accept edge to the assertion of complete_*.
REQ-026 A request present in WAIT or RESP SHALL be ignored, so back-to-back requests are accepted no sooner than one cycle after complete_*.
REQ-027 Address mapping SHALL be index = (addr - BASE_ADDR) modulo 2^16; the access is in-window iff index < 2^MEM_AW.
REQ-028 A read SHALL sample memory on the edge entering RESP, and the result SHALL be registered onto Instr_dout or Data_dout, which hold their value until the next completion.
REQ-029 A write SHALL commit on the edge entering RESP, and Data_dout SHALL be unchanged by a write.
REQ-030 An out-of-window access SHALL still complete normally, reads SHALL return 16'h0000, writes SHALL be dropped, and oob_err SHALL be set until reset.
REQ-031 When a data write and an instruction read target the same index on the same edge, the instruction read SHALL return the old data.
REQ-032 ld_we SHALL write memory on any edge, including during reset, and a preload out of window SHALL be dropped without setting oob_err.
REQ-033 When ld_we and a data write target the same index on the same edge, the ld_data value SHALL win.

Reset
REQ-034 Reset SHALL force both FSMs to IDLE, set Instr_dout=0, Data_dout=0, complete_instr=0, complete_data=0, oob_err=0 and zero the wait counters.
REQ-035 Reset during WAIT or RESP SHALL drop the outstanding access: no completion pulse and no pending write committed.
REQ-036 Memory contents SHALL NOT be cleared by reset.
REQ-037 Requests SHALL be ignored while reset is high.

Configuration
REQ-038 The configuration macro SHALL be LC3_MEM_RAND_WAIT_EN.
REQ-039 When LC3_MEM_RAND_WAIT_EN is defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL be seeded to 16'hACE1 on reset and advance every cycle.
REQ-040 When LC3_MEM_RAND_WAIT_EN is defined, W at accept SHALL be lfsr[3:0] mod (T_*_MAX+1).
REQ-041 When LC3_MEM_RAND_WAIT_EN is undefined, W SHALL be the fixed value T_*_MAX and no LFSR logic SHALL be present.

Verification
REQ-042 The bench SHALL cover: preload 16'h3000=16'h1021; T_FETCH_MAX=0; pc=16'h3000, instrmem_rd=1 at edge k -> complete_instr=1 during cycle k+1, Instr_dout=16'h1021.
REQ-043 The bench SHALL cover: T_DATA_MAX=3; write 16'hBEEF to 16'h3010 at edge k -> complete_data pulses during cycle k+4; a following read of 16'h3010 returns 16'hBEEF.
REQ-044 The bench SHALL cover: read Data_addr=16'h2FFF -> Data_dout=16'h0000, complete_data pulses, oob_err=1 and stays high until reset.
REQ-045 The bench SHALL cover: T_FETCH_MAX=5; assert reset two cycles after accept -> no complete_instr, Instr_dout=0, FSM IDLE, memory intact.
REQ-046 The bench SHALL cover: same-edge data write 16'h0001 and fetch at 16'h3020 (old 16'h5555) -> Instr_dout=16'h5555, and a later fetch returns 16'h0001.
REQ-047 The bench SHALL cover: LC3_MEM_RAND_WAIT_EN defined, T_DATA_MAX=7, 1000 reads -> every latency in 1..8 and the latency sequence identical across two runs.
